// File: rtl/fp_div_seq.sv
// -----------------------------------------------------------------------------
// fp_div_seq
// Sequential IEEE-754 single-precision divider. The mantissa quotient comes
// from a restoring divider that produces one bit per clock, followed by a
// single normalise/saturate step. Denormals are flushed to zero, exponent 255
// is used as an ordinary number, and the quotient is truncated (no rounding).
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   in_valid     operand pair a/b valid
//   in_ready     block can accept operands (idle)
//   a, b         IEEE-754 single dividend / divisor
//   out_valid    result/div_by_zero valid
//   out_ready    consumer accepts the result
//   result       quotient a/b (registered)
//   div_by_zero  divisor exponent field was zero for this result (registered)
// -----------------------------------------------------------------------------
module fp_div_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        div_by_zero
);

  typedef enum logic [1:0] {IDLE, CALC, NORM, DONE} state_t;

  state_t      state;
  state_t      state_nxt;

  logic        sign_q;
  logic [7:0]  ea_q;
  logic [7:0]  eb_q;
  logic [23:0] mb_q;
  logic [24:0] r_q;
  logic [24:0] q_q;
  logic [4:0]  cnt_q;

  // Operand decode, used only on the accept edge.
  logic       a_zero;
  logic       b_zero;
  logic       s_in;
  assign a_zero = (a[30:23] == 8'h00);
  assign b_zero = (b[30:23] == 8'h00);
  assign s_in   = a[31] ^ b[31];

  // Restoring-division step.
  logic        r_ge;
  logic [24:0] r_sub;
  assign r_ge  = (r_q >= {1'b0, mb_q});
  assign r_sub = r_q - {1'b0, mb_q};

  // Normalisation: q lies in [2^23, 2^25), so at most one position of shift.
  logic signed [9:0] e_norm;
  logic [22:0]       mant_norm;
  assign e_norm    = $signed({2'b00, ea_q}) - $signed({2'b00, eb_q})
                   + (q_q[24] ? 10'sd127 : 10'sd126);
  assign mant_norm = q_q[24] ? q_q[23:1] : q_q[22:0];

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave it unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_valid) state_nxt = (a_zero || b_zero) ? DONE : CALC;
      CALC: if (cnt_q == 5'd0) state_nxt = NORM;
      NORM: state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: reset is synchronous here, so it is sampled inside the clocked
  // branch and takes priority over every handshake on the same edge.
  // NOTE: all state is updated with non-blocking assignments so every register
  // sees the pre-edge values of the others, matching the hardware.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      result      <= 32'h0;
      div_by_zero <= 1'b0;
      sign_q      <= 1'b0;
      ea_q        <= 8'h00;
      eb_q        <= 8'h00;
      mb_q        <= 24'h0;
      r_q         <= 25'h0;
      q_q         <= 25'h0;
      cnt_q       <= 5'd0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (in_valid) begin
            sign_q <= s_in;
            ea_q   <= a[30:23];
            eb_q   <= b[30:23];
            mb_q   <= {1'b1, b[22:0]};
            r_q    <= {2'b01, a[22:0]};
            q_q    <= 25'h0;
            cnt_q  <= 5'd24;
            // Zero operands bypass the divider and finish straight away.
            if (b_zero) begin
              div_by_zero <= 1'b1;
              result      <= a_zero ? 32'h7FC0_0000 : {s_in, 8'hFF, 23'h0};
            end else if (a_zero) begin
              div_by_zero <= 1'b0;
              result      <= {s_in, 31'h0};
            end
          end
        end
        CALC: begin
          // Quotient bits arrive MSB first; shifting them in from the LSB
          // over exactly 25 steps places each one at q[cnt].
          q_q   <= {q_q[23:0], r_ge};
          r_q   <= r_ge ? {r_sub[23:0], 1'b0} : {r_q[23:0], 1'b0};
          cnt_q <= (cnt_q == 5'd0) ? 5'd0 : cnt_q - 5'd1;
        end
        NORM: begin
          div_by_zero <= 1'b0;
          if (e_norm <= 10'sd0)
            result <= {sign_q, 31'h0};
          else if (e_norm >= 10'sd255)
            result <= {sign_q, 8'hFF, 23'h0};
          else
            result <= {sign_q, e_norm[7:0], mant_norm};
        end
        default: ;  // DONE holds result and flag until the consumer takes them
      endcase
    end
  end

endmodule

// File: tb/tb_fp_div_seq.sv
// -----------------------------------------------------------------------------
// tb_fp_div_seq
// Directed bench for fp_div_seq. A behavioural model computes each quotient
// with plain integer division on the mantissas; a monitor compares every
// valid output cycle against it, and each directed vector also carries a
// hand-computed literal that pins the model.
// -----------------------------------------------------------------------------
module tb_fp_div_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        div_by_zero;

  int n_checks = 0;
  int n_fail   = 0;

  logic [32:0] exp_q[$];   // {div_by_zero, result}

  fp_div_seq dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference quotient from the numeric rules: sign xor, flushed zeros,
  // mantissa quotient floor(ma*2^24/mb), truncation, saturation.
  function automatic logic [32:0] model(input logic [31:0] x, input logic [31:0] y);
    logic        s;
    int          ex, ey, e;
    longint      mx, my, q, mant;
    s  = x[31] ^ y[31];
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    if (ey == 0)
      return (ex != 0) ? {1'b1, s, 8'hFF, 23'h0} : {1'b1, 32'h7FC0_0000};
    if (ex == 0)
      return {1'b0, s, 31'h0};
    mx = longint'({1'b1, x[22:0]});
    my = longint'({1'b1, y[22:0]});
    q  = (mx * 64'd16777216) / my;
    if (q >= 64'd16777216) begin
      e    = ex - ey + 127;
      mant = (q / 2) % 64'd8388608;
    end else begin
      e    = ex - ey + 126;
      mant = q % 64'd8388608;
    end
    if (e <= 0)   return {1'b0, s, 31'h0};
    if (e >= 255) return {1'b0, s, 8'hFF, 23'h0};
    return {1'b0, s, e[7:0], mant[22:0]};
  endfunction

  // Output monitor: every cycle with out_valid must match the oldest
  // outstanding model result; the entry retires when the handshake will fire.
  always @(negedge clk) begin
    if (!reset) begin
      check("ready_valid_exclusive", {31'h0, in_ready & out_valid}, 32'h0);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_out_valid", {31'h0, out_valid}, 32'h0);
        end else begin
          check("model_result", result, exp_q[0][31:0]);
          check("model_div_by_zero", {31'h0, div_by_zero}, {31'h0, exp_q[0][32]});
          if (out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  // Drives one operand pair and completes its handshake. All timing is taken
  // #1 after a rising edge. Latency counts edges including the accept edge.
  task automatic do_op(input logic [31:0] x, input logic [31:0] y,
                       input bit use_lit, input logic [31:0] lit_res,
                       input logic lit_dbz, input int hold);
    logic [32:0] m;
    int          lat;
    int          guard;
    int          exp_lat;
    logic [31:0] held;
    guard = 0;
    while (!in_ready && guard < 100) begin
      @(posedge clk); #1; guard++;
    end
    check("in_ready_before_op", {31'h0, in_ready}, 32'h1);
    m = model(x, y);
    if (use_lit) begin
      check("model_pin_result", m[31:0], lit_res);
      check("model_pin_dbz", {31'h0, m[32]}, {31'h0, lit_dbz});
    end
    exp_lat = (x[30:23] == 8'h00 || y[30:23] == 8'h00) ? 1 : 27;
    a = x; b = y; in_valid = 1'b1;
    exp_q.push_back(m);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = $urandom; b = $urandom;   // must be ignored after the accept edge
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    check("latency", lat, exp_lat);
    if (use_lit) begin
      check("lit_result", result, lit_res);
      check("lit_div_by_zero", {31'h0, div_by_zero}, {31'h0, lit_dbz});
    end
    held = result;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_out_valid", {31'h0, out_valid}, 32'h1);
      check("hold_in_ready", {31'h0, in_ready}, 32'h0);
      check("hold_result", result, held);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("post_ack_out_valid", {31'h0, out_valid}, 32'h0);
    check("post_ack_in_ready", {31'h0, in_ready}, 32'h1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = 32'h0; b = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_in_ready", {31'h0, in_ready}, 32'h1);
    check("reset_out_valid", {31'h0, out_valid}, 32'h0);
    check("reset_result", result, 32'h0);
    check("reset_div_by_zero", {31'h0, div_by_zero}, 32'h0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Directed vectors with hand-computed results.
    do_op(32'h40C0_0000, 32'h4000_0000, 1, 32'h4040_0000, 1'b0, 0);  // 6/2
    do_op(32'h3F80_0000, 32'h4040_0000, 1, 32'h3EAA_AAAA, 1'b0, 0);  // 1/3
    do_op(32'hBF80_0000, 32'h4000_0000, 1, 32'hBF00_0000, 1'b0, 0);  // -1/2
    do_op(32'h40E0_0000, 32'hC000_0000, 1, 32'hC060_0000, 1'b0, 0);  // 7/-2
    do_op(32'h3F80_0000, 32'h0000_0000, 1, 32'h7F80_0000, 1'b1, 0);  // 1/0
    do_op(32'h0000_0000, 32'h0000_0000, 1, 32'h7FC0_0000, 1'b1, 0);  // 0/0
    do_op(32'h8000_0000, 32'h3F80_0000, 1, 32'h8000_0000, 1'b0, 0);  // -0/1
    do_op(32'h0080_0000, 32'h7F00_0000, 1, 32'h0000_0000, 1'b0, 0);  // underflow
    do_op(32'h7F00_0000, 32'h0080_0000, 1, 32'h7F80_0000, 1'b0, 0);  // overflow
    do_op(32'h0080_0000, 32'h3F80_0000, 1, 32'h0080_0000, 1'b0, 0);  // e == 1
    do_op(32'h7F80_0000, 32'h3F80_0000, 1, 32'h7F80_0000, 1'b0, 0);  // ea = 255
    do_op(32'h40C0_0000, 32'h4000_0000, 1, 32'h4040_0000, 1'b0, 10); // backpressure

    // Model-only vectors.
    for (int i = 0; i < 6; i++)
      do_op($urandom, $urandom, 0, 32'h0, 1'b0, i % 3);

    // Reset in the middle of a division aborts it; an operand offered on the
    // reset edge is discarded.
    a = 32'h40C0_0000; b = 32'h4000_0000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1; in_valid = 1'b1; a = 32'h3F80_0000; b = 32'h0000_0000;
    @(posedge clk); #1;
    reset = 1'b0; in_valid = 1'b0;
    exp_q.delete();
    check("abort_out_valid", {31'h0, out_valid}, 32'h0);
    check("abort_result", result, 32'h0);
    check("abort_in_ready", {31'h0, in_ready}, 32'h1);
    repeat (30) @(posedge clk);
    #1;
    check("abort_still_idle", {31'h0, in_ready}, 32'h1);
    do_op(32'h40C0_0000, 32'h4000_0000, 1, 32'h4040_0000, 1'b0, 0);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
